ro_trng_core: RTL



---
 rtl/ro_trng_pkg.sv | 37 +++
 rtl/ro_pair_ch.sv | 30 +++
 rtl/ro_trng_core.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ro_trng_pkg.sv
// ro_trng_pkg: shared types and elaboration helpers for the ring-oscillator
// entropy source.
//   trng_state_t : conditioning FSM states (IDLE, WARMUP, RUN, ALARM)
//   clog2        : counter width helper, never returns less than 1
//   params_ok    : parameter legality check evaluated at elaboration
package ro_trng_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WARMUP = 2'd1,
      RUN    = 2'd2,
      ALARM  = 2'd3
   } trng_state_t;

   // Bits needed to hold values 0..value-1, with a floor of one bit so that
   // degenerate counters (e.g. no decimation) still have a legal width.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) < 64'(value)) w++;
      return w;
   endfunction

   function automatic bit params_ok(input int unsigned num_ch,
                                    input int unsigned len_a,
                                    input int unsigned len_b,
                                    input int unsigned word_w,
                                    input int unsigned decim,
                                    input int unsigned warmup_cyc,
                                    input int unsigned rct_limit);
      return (len_a != len_b) && (len_a >= 1) && (len_b >= 1) &&
             (decim >= 1) && (rct_limit >= 2) && (warmup_cyc >= 1) &&
             (num_ch >= 1) && (num_ch <= 32) &&
             (word_w >= 8) && (word_w <= 64);
   endfunction

endpackage

// File: rtl/ro_pair_ch.sv
// ro_pair_ch: one entropy channel built from two free-running ring
// oscillators of different lengths whose outputs are XORed.
//   en     : gates both rings through their NAND stage; low stops oscillation
//   ro_bit : XOR of the two ring outputs (asynchronous, must be synchronised)
// Each ring is a NAND followed by 2*LEN inverters, giving an odd number of
// inversions so the loop cannot settle while enabled.
module ro_pair_ch #(
   parameter int unsigned LEN_A = 1,
   parameter int unsigned LEN_B = 2
) (
   input  logic en,
   output logic ro_bit
);

   logic [2*LEN_A:0] ring_a;
   logic [2*LEN_B:0] ring_b;

   assign ring_a[0] = ~(en & ring_a[2*LEN_A]);
   for (genvar i = 1; i <= 2*LEN_A; i++) begin : g_ring_a
      assign ring_a[i] = ~ring_a[i-1];
   end

   assign ring_b[0] = ~(en & ring_b[2*LEN_B]);
   for (genvar i = 1; i <= 2*LEN_B; i++) begin : g_ring_b
      assign ring_b[i] = ~ring_b[i-1];
   end

   assign ro_bit = ring_a[2*LEN_A] ^ ring_b[2*LEN_B];

endmodule

// File: rtl/ro_trng_core.sv
// ro_trng_core: ring-oscillator true random number source with conditioning.
//   clk, rst  : single clock, synchronous active-high reset
//   en        : enable; low stops the rings and returns the FSM to IDLE
//   sim_bits  : per-channel substitute entropy when SIM_ENTROPY=1
//   rnd_data  : assembled random word, stable while rnd_valid && !rnd_ready
//   rnd_valid : rnd_data holds a word not yet consumed
//   rnd_ready : consumer accepts rnd_data this cycle
//   alarm     : sticky repetition-count failure, cleared only by en=0 or rst
//   running   : FSM is in RUN
// Path: XOR of channels -> 2-FF synchroniser -> decimator -> (health test on
// decimated bits) -> optional von Neumann debiaser -> word assembler.
module ro_trng_core
   import ro_trng_pkg::*;
#(
   parameter int unsigned NUM_CH      = 8,
   parameter int unsigned LEN_A       = 1,
   parameter int unsigned LEN_B       = 2,
   parameter int unsigned WORD_W      = 32,
   parameter int unsigned DECIM       = 4,
   parameter int unsigned DEBIAS      = 1,
   parameter int unsigned WARMUP_CYC  = 64,
   parameter int unsigned RCT_LIMIT   = 32,
   parameter int unsigned SIM_ENTROPY = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NUM_CH-1:0] sim_bits,
   output logic [WORD_W-1:0] rnd_data,
   output logic              rnd_valid,
   input  logic              rnd_ready,
   output logic              alarm,
   output logic              running
);

   localparam int unsigned WCW = clog2(WARMUP_CYC);
   localparam int unsigned DCW = clog2(DECIM);
   localparam int unsigned RCW = clog2(RCT_LIMIT + 1);
   localparam int unsigned BCW = clog2(WORD_W);

   if (!params_ok(NUM_CH, LEN_A, LEN_B, WORD_W, DECIM, WARMUP_CYC, RCT_LIMIT)) begin : g_param_check
      $error("ro_trng_core: illegal parameter combination");
   end

   // ---------------------------------------------------------------
   // Raw entropy: XOR of all channels, or of sim_bits in simulation.
   // ---------------------------------------------------------------
   logic raw;

   if (SIM_ENTROPY != 0) begin : g_sim
      assign raw = ^sim_bits;
   end else begin : g_ro
      logic [NUM_CH-1:0] ch_bits;
      logic              sim_unused;
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         ro_pair_ch #(
            .LEN_A (LEN_A),
            .LEN_B (LEN_B)
         ) u_ch (
            .en     (en),
            .ro_bit (ch_bits[c])
         );
      end
      assign raw        = ^ch_bits;
      assign sim_unused = ^sim_bits;
   end

   logic sync1;
   logic raw_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= 1'b0;
         raw_sync <= 1'b0;
      end else begin
         sync1    <= raw;
         raw_sync <= sync1;
      end
   end

   // ---------------------------------------------------------------
   // Conditioning state
   // ---------------------------------------------------------------
   trng_state_t       state;
   logic [WCW-1:0]    warm_cnt;

   logic [DCW-1:0]    dec_cnt;
   logic              dec_acc;
   logic              have_first;
   logic              first_bit;
   logic              have_last;
   logic              last_bit;
   logic [RCW-1:0]    rct_cnt;
   logic [BCW-1:0]    bit_cnt;
   logic [WORD_W-1:0] shreg;

   logic              run_act;
   logic              dec_bit;
   logic              dec_strobe;
   logic [RCW-1:0]    rct_next;
   logic              rct_fail;
   logic              emit;
   logic              emit_bit;
   logic [WORD_W-1:0] shreg_next;
   logic              word_done;

   // Decimated bit, health test, debias and assembler all evaluate in the
   // same cycle so one strobe updates every stage at a single edge.
   always_comb begin
      run_act    = (state == RUN) && en;
      dec_bit    = dec_acc ^ raw_sync;
      dec_strobe = run_act && (dec_cnt == DCW'(DECIM - 1));
      rct_next   = (have_last && (dec_bit == last_bit)) ? rct_cnt + 1'b1 : RCW'(1);
      rct_fail   = dec_strobe && (rct_next == RCW'(RCT_LIMIT));
      if (DEBIAS != 0) begin
         // 01 -> 0 and 10 -> 1: the emitted value is the first bit of the pair.
         emit     = dec_strobe && have_first && (first_bit != dec_bit);
         emit_bit = first_bit;
      end else begin
         emit     = dec_strobe;
         emit_bit = dec_bit;
      end
      shreg_next = {shreg[WORD_W-2:0], emit_bit};
      // A word finishing on the failing bit is discarded with the partial word.
      word_done  = emit && (bit_cnt == BCW'(WORD_W - 1)) && !rct_fail;
   end

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         warm_cnt <= '0;
         running  <= 1'b0;
         alarm    <= 1'b0;
      end else if (!en) begin
         state    <= IDLE;
         warm_cnt <= '0;
         running  <= 1'b0;
         alarm    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state    <= WARMUP;
               warm_cnt <= '0;
            end
            WARMUP: begin
               if (warm_cnt == WCW'(WARMUP_CYC - 1)) begin
                  state   <= RUN;
                  running <= 1'b1;
               end else begin
                  warm_cnt <= warm_cnt + 1'b1;
               end
            end
            RUN: begin
               if (rct_fail) begin
                  state   <= ALARM;
                  running <= 1'b0;
                  alarm   <= 1'b1;
               end
            end
            ALARM: begin
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Datapath: decimator, health test, debiaser, assembler, output
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         dec_cnt    <= '0;
         dec_acc    <= 1'b0;
         have_first <= 1'b0;
         first_bit  <= 1'b0;
         have_last  <= 1'b0;
         last_bit   <= 1'b0;
         rct_cnt    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         rnd_data   <= '0;
         rnd_valid  <= 1'b0;
      end else begin
         // Holding every stage clear outside RUN makes each RUN entry start
         // from an empty pair slot, fresh decimation group and no partial word.
         if (!run_act) begin
            dec_cnt    <= '0;
            dec_acc    <= 1'b0;
            have_first <= 1'b0;
            first_bit  <= 1'b0;
            have_last  <= 1'b0;
            last_bit   <= 1'b0;
            rct_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
         end else begin
            if (dec_strobe) begin
               dec_cnt   <= '0;
               dec_acc   <= 1'b0;
               have_last <= 1'b1;
               last_bit  <= dec_bit;
               rct_cnt   <= rct_next;
               if (have_first) begin
                  have_first <= 1'b0;
               end else begin
                  have_first <= 1'b1;
                  first_bit  <= dec_bit;
               end
            end else begin
               dec_cnt <= dec_cnt + 1'b1;
               dec_acc <= dec_bit;
            end
            if (emit) begin
               shreg   <= shreg_next;
               bit_cnt <= (bit_cnt == BCW'(WORD_W - 1)) ? '0 : bit_cnt + 1'b1;
            end
         end

         // An occupied, unconsumed output wins: a finishing word is dropped.
         if (rct_fail || (state == ALARM)) begin
            rnd_valid <= 1'b0;
         end else if (word_done && (!rnd_valid || rnd_ready)) begin
            rnd_data  <= shreg_next;
            rnd_valid <= 1'b1;
         end else if (rnd_valid && rnd_ready) begin
            rnd_valid <= 1'b0;
         end
      end
   end

endmodule
